// File: rtl/memoria_pkg.sv
// memoria_pkg -- constants shared by the memory writer and the ROM reader.
//   WIDTH  : data word width in bits
//   DEPTH  : number of memory words (power of two)
//   ADDR_W : address width, log2(DEPTH)
package memoria_pkg;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = $clog2(DEPTH);

endpackage : memoria_pkg

// File: rtl/memoria_escritor_if.sv
// memoria_escritor_if -- write/read/status bundle of the memory writer.
//   iEscribir, iDato  : write strobe and word to store
//   iBorrar           : clear pointer, count and overflow flag
//   iLeer, iDirLeer   : read strobe and read address
//   ovalor, oValido   : registered read data and its valid flag
//   oCuenta           : words stored (0..DEPTH)
//   oLleno, oDesborde : full flag and sticky overflow flag
// Modports: master drives the strobes (client/testbench), slave is the writer.
interface memoria_escritor_if #(
   parameter int WIDTH = memoria_pkg::WIDTH,
   parameter int DEPTH = memoria_pkg::DEPTH
);

   localparam int ADDR_W = $clog2(DEPTH);

   logic              iEscribir;
   logic [WIDTH-1:0]  iDato;
   logic              iBorrar;
   logic              iLeer;
   logic [ADDR_W-1:0] iDirLeer;
   logic [WIDTH-1:0]  ovalor;
   logic              oValido;
   logic [ADDR_W:0]   oCuenta;
   logic              oLleno;
   logic              oDesborde;

   modport master (
      output iEscribir, iDato, iBorrar, iLeer, iDirLeer,
      input  ovalor, oValido, oCuenta, oLleno, oDesborde
   );

   modport slave (
      input  iEscribir, iDato, iBorrar, iLeer, iDirLeer,
      output ovalor, oValido, oCuenta, oLleno, oDesborde
   );

endinterface : memoria_escritor_if

// File: rtl/memoria_ram.sv
// memoria_ram -- simple dual-port storage, one write port and one
// synchronous read port, no reset.
//   clk          : clock
//   escribir     : write enable
//   dir_escribir : write address
//   dato         : write data
//   leer         : read enable; q is updated only when set
//   dir_leer     : read address
//   q            : read data, valid the cycle after leer, held otherwise
module memoria_ram #(
   parameter  int WIDTH  = memoria_pkg::WIDTH,
   parameter  int DEPTH  = memoria_pkg::DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              escribir,
   input  logic [ADDR_W-1:0] dir_escribir,
   input  logic [WIDTH-1:0]  dato,
   input  logic              leer,
   input  logic [ADDR_W-1:0] dir_leer,
   output logic [WIDTH-1:0]  q
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: storage has no reset on purpose; clearing an array costs a
   // mux per bit and blocks inference as block RAM.
   // NOTE: non-blocking assignments make a same-address read see the word
   // that was there before this edge (read-before-write).
   always_ff @(posedge clk) begin
      if (escribir) mem[dir_escribir] <= dato;
      if (leer)     q <= mem[dir_leer];
   end

endmodule : memoria_ram

// File: rtl/memoria_escritor.sv
// memoria_escritor -- sequential writer into a DEPTH-word memory with
// random-access reads.
//   iClk    : clock, all state updates on the rising edge
//   iReset  : synchronous active-high reset (pointer, count, flags, read data)
//   bus     : memoria_escritor_if slave (strobes in, data and status out)
// Writes fill addresses 0,1,2,... until the memory is full; further writes
// are dropped and flag overflow. iBorrar empties the pointer/count without
// touching the stored words.
module memoria_escritor #(
   parameter int WIDTH = memoria_pkg::WIDTH,
   parameter int DEPTH = memoria_pkg::DEPTH
) (
   input logic               iClk,
   input logic               iReset,
   memoria_escritor_if.slave bus
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] CUENTA_MAX = (ADDR_W + 1)'(DEPTH);

   logic [ADDR_W-1:0] puntero;
   logic [ADDR_W:0]   cuenta;
   logic              desborde;
   logic              valido;
   logic              cargado;   // ovalor has been loaded since reset
   logic              lleno;
   logic              aceptar;
   logic              leer_ram;
   logic [WIDTH-1:0]  ram_q;

   assign lleno    = (cuenta == CUENTA_MAX);
   assign aceptar  = bus.iEscribir & ~lleno & ~bus.iBorrar & ~iReset;
   assign leer_ram = bus.iLeer & ~iReset;

   memoria_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk          (iClk),
      .escribir     (aceptar),
      .dir_escribir (puntero),
      .dato         (bus.iDato),
      .leer         (leer_ram),
      .dir_leer     (bus.iDirLeer),
      .q            (ram_q)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values present before the edge.
   always_ff @(posedge iClk) begin
      if (iReset) begin
         puntero  <= '0;
         cuenta   <= '0;
         desborde <= 1'b0;
         valido   <= 1'b0;
         cargado  <= 1'b0;
      end else begin
         if (bus.iBorrar) begin
            puntero  <= '0;
            cuenta   <= '0;
            desborde <= 1'b0;
         end else if (bus.iEscribir) begin
            if (lleno) begin
               desborde <= 1'b1;
            end else begin
               puntero <= puntero + 1'b1;   // wraps DEPTH-1 -> 0
               cuenta  <= cuenta + 1'b1;
            end
         end
         valido <= bus.iLeer;
         if (bus.iLeer) cargado <= 1'b1;
      end
   end

   // The RAM's read register has no reset; until the first read after reset
   // its output is forced to zero so ovalor reads 0 out of reset.
   assign bus.ovalor    = cargado ? ram_q : '0;
   assign bus.oValido   = valido;
   assign bus.oCuenta   = cuenta;
   assign bus.oLleno    = lleno;
   assign bus.oDesborde = desborde;

endmodule : memoria_escritor

// File: doc/memoria_escritor.md
MEMORIA_ESCRITOR -- requirements
Module: memoria_escritor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, number of memory words (power of two).
REQ-003 The block SHALL have ports, clock and reset first:
  iClk       input   1              single clock; all state updates on rising edge
  iReset     input   1              synchronous, active-high reset
  iEscribir  input   1              write strobe; one word stored per asserted cycle
  iDato      input   WIDTH          word to store
  iBorrar    input   1              clear: empties memory pointer and count
  iLeer      input   1              read strobe
  iDirLeer   input   log2(DEPTH)    read address
  ovalor     output  WIDTH          registered read data
  oValido    output  1              ovalor holds data from the previous cycle's read
  oCuenta    output  log2(DEPTH)+1  number of words stored, 0..DEPTH
  oLleno     output  1              oCuenta == DEPTH
  oDesborde  output  1              sticky: a write was attempted while full

Function
REQ-004 The write pointer SHALL start at 0 and advance by 1 per accepted write.
REQ-005 A write SHALL be accepted when iEscribir=1, oLleno=0, iBorrar=0 and iReset=0.
REQ-006 An accepted write SHALL store iDato at the write-pointer address, visible to reads from the next cycle.
REQ-007 Each accepted write SHALL increment oCuenta by 1.
REQ-008 The pointer SHALL wrap from DEPTH-1 to 0, with oLleno asserting in the same cycle that oCuenta reaches DEPTH.
REQ-009 A write attempted while oLleno=1 SHALL be discarded, leaving memory, pointer and oCuenta unchanged.
REQ-010 A write attempted while oLleno=1 SHALL set oDesborde, which stays 1 until iBorrar or iReset.
REQ-011 iBorrar SHALL, on the next edge, set the pointer, oCuenta and oDesborde to 0 without altering memory contents.
REQ-012 iBorrar SHALL take precedence over a simultaneous iEscribir, which is discarded and does not set oDesborde.
REQ-013 Reads SHALL have 1-cycle latency: iLeer=1 at edge N loads ovalor with mem[iDirLeer] and sets oValido=1 at edge N.
REQ-014 oValido SHALL be 0 after any cycle with iLeer=0, and ovalor SHALL hold its last value.
REQ-015 A read and a write to the same address in the same cycle SHALL return the old contents (read-before-write).
REQ-016 Reads SHALL be allowed at any address regardless of oCuenta, and SHALL not modify any state.
REQ-017 oLleno SHALL be combinationally decoded from oCuenta; all other outputs SHALL be registered.

Reset
REQ-018 While iReset=1 at a rising edge, pointer, oCuenta, oDesborde, oValido and ovalor SHALL become 0.
REQ-019 iReset SHALL take precedence over iBorrar, iEscribir and iLeer.
REQ-020 iReset SHALL not clear memory contents; contents after reset SHALL be treated as undefined.
REQ-021 Reset asserted mid-fill SHALL leave the block empty, with the next accepted write going to address 0.

Structure
REQ-022 WIDTH, DEPTH and derived ADDR_W = log2(DEPTH) SHALL be constants in the shared package memoria_pkg, also used by the existing ROM reader.
REQ-023 Storage SHALL be a sub-module memoria_ram: one write port, one synchronous read port, no reset.
REQ-024 Pointer, count, flags and read-output registers SHALL be in memoria_escritor.

Verification
REQ-025 Write 0x11,0x22,0x33 on consecutive cycles, then read addresses 0,1,2 -> ovalor 0x11,0x22,0x33 one cycle after each read; oCuenta=3.
REQ-026 16 writes of 0x00..0x0F -> oLleno=1 after the 16th, oCuenta=16; a 17th write of 0xAA -> oDesborde=1 and mem[0] still 0x00.
REQ-027 Full and overflowed, then assert iBorrar with iEscribir=1 -> oCuenta=0, oDesborde=0, oLleno=0; next write 0x55 lands at address 0.
REQ-028 Write 0x77 at address 2 while reading address 2 in the same cycle -> ovalor shows old data; a re-read next cycle -> 0x77.
REQ-029 Assert iReset after 5 writes -> all outputs 0; write 0x99 then read address 0 -> 0x99, oCuenta=1.
REQ-030 iLeer pulsed for one cycle -> oValido=1 for exactly one cycle, and ovalor holds afterwards.
